// File: rtl/dmem_responder.sv
// Word-addressed data memory responder: one outstanding request, fixed latency.
// Optional byte-lane writes are enabled by defining DMEM_RESPONDER_BYTE_WRITE_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]  state;
    logic [3:0]  cnt;

    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        access;
    logic        live;
    logic        a_write;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_be;
    logic [3:0]  a_wmask;
    logic        a_err;
    logic [AW-1:0] a_idx;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;

    always_comb begin
        access = 1'b0;
        if (LATENCY == 1)
            access = accept;
        else
            access = (state == WAIT) && (cnt == 4'd1);
    end

    // With LATENCY = 1 the access happens on the acceptance edge,
    // so the live request fields are used instead of the captured ones.
    assign live    = (state == IDLE);
    assign a_write = live ? req_write : r_write;
    assign a_addr  = live ? req_addr  : r_addr;
    assign a_wdata = live ? req_wdata : r_wdata;
    assign a_be    = live ? req_be    : r_be;

    assign a_err = (a_addr[1:0] != 2'b00)
                || (a_addr[31:2] >= 30'(DEPTH_WORDS));
    assign a_idx = a_addr[AW+1:2];

`ifdef DMEM_RESPONDER_BYTE_WRITE_EN
    assign a_wmask = a_be;
`else
    logic unused_be;
    assign unused_be = ^a_be;
    assign a_wmask   = 4'hF;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_be    <= req_be;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= RESP;
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (access) begin
                rsp_err   <= a_err;
                rsp_rdata <= (a_err || a_write) ? 32'd0 : mem[a_idx];
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && access && a_write && !a_err) begin
            for (int b = 0; b < 4; b++) begin
                if (a_wmask[b])
                    mem[a_idx][8*b +: 8] <= a_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit words stored; legal range 4..65536, power of two.
REQ-002 SHALL have parameter LATENCY, default 2: rising edges from request acceptance to first cycle of rsp_valid; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_be  input  4  byte enables; bit i selects req_wdata[8i+7:8i].
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  initiator consumes the response.
REQ-013 SHALL have port rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  request was rejected (misaligned or out of range).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE (combinational from state); rsp_valid = 1 only in RESP.
REQ-016 SHALL accept a request on an edge where req_valid & req_ready; all request fields SHALL be captured into internal registers on that edge and be ignored until the next acceptance.
REQ-017 On acceptance with LATENCY = 1: SHALL perform the access on the acceptance edge and go to RESP.
REQ-018 On acceptance with LATENCY > 1: SHALL go to WAIT, load the counter with LATENCY-1, decrement it on each WAIT edge, and on the WAIT edge where counter = 1 perform the access and go to RESP.
REQ-019 rsp_valid SHALL therefore first be sampled high at the LATENCY-th rising edge after the acceptance edge.
REQ-020 A request SHALL be an error when req_addr[1:0] != 0, or when req_addr[31:2] >= DEPTH_WORDS.
REQ-021 Error access: no memory change; rsp_err = 1; rsp_rdata = 0.
REQ-022 Valid load: rsp_rdata = word[req_addr[31:2]] as held before the access edge; rsp_err = 0.
REQ-023 Valid store: for each set req_be bit, the corresponding byte of the word is updated on the access edge; rsp_rdata = 0; rsp_err = 0.
REQ-024 A store with req_be = 0 SHALL be a legal no-op that still returns a response.
REQ-025 rsp_rdata and rsp_err SHALL be held stable throughout RESP.
REQ-026 RESP SHALL go to IDLE on the edge where rsp_ready = 1; otherwise it stays in RESP indefinitely.
REQ-027 A new request SHALL NOT be accepted in the same cycle that a response is consumed; it is accepted at the earliest on the next cycle, in IDLE.
REQ-028 req_valid asserted outside IDLE SHALL have no effect.
REQ-029 Memory contents SHALL be read in the same word order they were written, with the byte lane mapping little-endian: byte 0 = bits [7:0].

Reset
REQ-030 On an edge with rst = 1: state SHALL go to IDLE, the counter to 0, rsp_rdata to 0, and rsp_err to 0; therefore req_ready = 1 and rsp_valid = 0 in the cycle after.
REQ-031 rst during WAIT SHALL abort the pending request before its access edge: no memory write and no response.
REQ-032 rst during RESP SHALL discard the response, even if rsp_ready is asserted in the same cycle.
REQ-033 rst SHALL NOT clear memory contents; the contents after power-up are undefined.
REQ-034 rst SHALL take priority over any acceptance or access on the same edge.

Configuration
REQ-035 Macro DMEM_RESPONDER_BYTE_WRITE_EN defined: req_be SHALL be honoured per REQ-023 and REQ-024.
REQ-036 Macro DMEM_RESPONDER_BYTE_WRITE_EN undefined: req_be SHALL be ignored; every valid store writes all 4 bytes, and REQ-024 does not apply.

Verification
REQ-037 Reset, then store addr 0x10, data 0xDEADBEEF, be 0xF; load 0x10 with LATENCY = 2 -> load rsp_valid sampled high exactly 2 edges after acceptance; rdata 0xDEADBEEF; err 0.
REQ-038 With macro defined: store 0x10, data 0x000000AA, be 0x1 onto 0xDEADBEEF -> load returns 0xDEADBEAA. With macro undefined: same stimulus -> load returns 0x000000AA.
REQ-039 Load addr 0x12 -> err 1, rdata 0. Load addr 4*DEPTH_WORDS (0x400 at default) -> err 1. A store to 0x400 -> err 1 and word 0 unchanged.
REQ-040 Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid stays 1, rdata stable, req_ready 0, new req_valid ignored; raise rsp_ready -> IDLE on the next edge; the next request is accepted one cycle later.
REQ-041 Store 0x20, data 0x12345678 to a word holding 0x0; assert rst for one cycle in WAIT -> no response; subsequent load 0x20 returns the prior value 0x0.
REQ-042 LATENCY = 1 with back-to-back requests and rsp_ready tied to 1 -> one response every 2 cycles; req_ready toggles 1,0,1,0.
